// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single external RAM port: round-robin between
// instruction fetch and operand access, with a programmable strobe width.
module ram_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_done,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_oe,
  input  logic [DW-1:0] ram_rdata,
  output logic          wram,
  output logic          rram,
  output logic          busy
);

  generate
    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait_cyc
      $error("ram_port_arbiter: WAIT_CYC must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       owner;       // 1 = data side, 0 = fetch side
  logic       last_owner;
  logic       we;
  logic       pick;
  logic       grant;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    // A lone requester wins outright; on a tie the side that did not go last wins.
    pick      = (f_req && d_req) ? ~last_owner : d_req;
    wram      = 1'b1;
    rram      = 1'b1;
    ram_oe    = 1'b0;
    busy      = (state != IDLE);
    f_gnt     = (state != IDLE) && !owner;
    d_gnt     = (state != IDLE) && owner;
    f_done    = 1'b0;
    d_done    = 1'b0;
    case (state)
      IDLE: begin
        if (run && (f_req || d_req)) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        wram   = ~we;
        rram   = we;
        ram_oe = we;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        f_done    = !owner;
        d_done    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we         <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      f_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= pick;
        last_owner <= pick;
        cnt        <= CNT_INIT;
        we         <= pick & d_we;
        ram_addr   <= pick ? d_addr : f_addr;
        if (pick) ram_wdata <= d_wdata;
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!we) begin
          // Read data is captured on the edge that ends the strobe.
          if (owner) d_rdata <= ram_rdata;
          else       f_rdata <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level arbitration and memory model.
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int WC = 3;

  logic          clk = 1'b0;
  logic          rst, run;
  logic          f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          f_gnt, f_done, d_gnt, d_done;
  logic [DW-1:0] f_rdata, d_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_oe, wram, rram, busy;

  logic [DW-1:0] mem     [256];
  logic          wr_flag [256];
  logic [DW-1:0] ref_mem [256];

  int            n_cmp = 0;
  int            n_err = 0;
  bit            last_owner;
  logic [DW-1:0] exp_f_rdata, exp_d_rdata;

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  // RAM: background pattern until a location has been written through the strobe.
  always @(posedge clk) begin
    if (wram === 1'b0) begin
      mem[ram_addr]     <= ram_wdata;
      wr_flag[ram_addr] <= 1'b1;
    end
  end
  assign ram_rdata = (wr_flag[ram_addr] === 1'b1) ? mem[ram_addr] : pat(ram_addr);

  ram_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst(rst), .run(run),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_oe(ram_oe), .ram_rdata(ram_rdata),
    .wram(wram), .rram(rram), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete access from request to the idle cycle after done.
  // own: 1 = data side won, 0 = fetch side won.
  task automatic run_txn(input bit stop_run, input bit drop_reqs, output bit own);
    int            n;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    own = (f_req && d_req) ? ~last_owner : d_req;
    we  = own & d_we;
    a   = own ? d_addr : f_addr;
    wd  = d_wdata;
    n = 0;
    while (!(f_gnt || d_gnt) && n < 12) begin
      step();
      n++;
    end
    chk("grant_latency", 32'(n), 32'd1);
    last_owner = own;
    chk("grant_pair", 32'({f_gnt, d_gnt}), own ? 32'd1 : 32'd2);
    chk("ram_addr", 32'(ram_addr), 32'(a));
    if (we) chk("ram_wdata", 32'(ram_wdata), 32'(wd));
    if (stop_run) run = 1'b0;
    n = 0;
    while (!(f_done || d_done) && n < 20) begin
      chk("access_strobes", 32'({wram, rram, ram_oe}), we ? 32'b011 : 32'b100);
      chk("access_busy", 32'(busy), 32'd1);
      step();
      n++;
    end
    chk("done_latency", 32'(n), 32'(WC));
    chk("done_pair", 32'({f_done, d_done}), own ? 32'd1 : 32'd2);
    chk("gnt_in_done", 32'({f_gnt, d_gnt}), own ? 32'd1 : 32'd2);
    chk("strobes_in_done", 32'({wram, rram, ram_oe}), 32'b110);
    if (we) begin
      ref_mem[a] = wd;
      chk("ram_written", 32'(mem[a]), 32'(wd));
    end else if (own) begin
      exp_d_rdata = ref_mem[a];
    end else begin
      exp_f_rdata = ref_mem[a];
    end
    chk("f_rdata", 32'(f_rdata), 32'(exp_f_rdata));
    chk("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
    if (drop_reqs) begin
      f_req = 1'b0;
      d_req = 1'b0;
    end
    step();
    chk("idle_after_done", 32'({busy, f_gnt, d_gnt, f_done, d_done}), 32'd0);
  endtask

  initial begin
    bit         own, prev;
    logic [1:0] r;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));

    // Reset held two cycles with both requests high.
    rst = 1'b0; run = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    step();
    step();
    chk("rst_strobes", 32'({wram, rram, ram_oe}), 32'b110);
    chk("rst_gnt", 32'({f_gnt, d_gnt}), 32'd0);
    chk("rst_done", 32'({f_done, d_done}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", 32'({f_rdata, d_rdata}), 32'd0);
    chk("rst_ram_regs", 32'({ram_addr, ram_wdata}), 32'd0);
    last_owner = 1'b1;
    exp_f_rdata = '0;
    exp_d_rdata = '0;
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0;
    step();

    // Single fetch read.
    f_req = 1'b1; f_addr = 8'h10;
    run_txn(1'b0, 1'b1, own);
    chk("t2_owner", 32'(own), 32'd0);
    chk("t2_f_rdata", 32'(f_rdata), 32'hA5);

    // Data write.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C;
    run_txn(1'b0, 1'b1, own);
    chk("t3_mem", 32'(mem[8'h20]), 32'h3C);

    // Continuous contention: grants must alternate.
    d_we = 1'b0; f_addr = 8'h20; d_addr = 8'h33;
    f_req = 1'b1; d_req = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b0, i == 5, own);
      if (i > 0) chk("t4_alternate", 32'(own != prev), 32'd1);
      prev = own;
    end

    // run dropped mid-access: completes, then no new grant until run returns.
    f_req = 1'b1; d_req = 1'b1; f_addr = 8'h05; d_addr = 8'h06;
    run_txn(1'b1, 1'b0, own);
    for (int i = 0; i < 5; i++) begin
      chk("t5_no_grant", 32'({busy, f_gnt, d_gnt}), 32'd0);
      step();
    end
    run = 1'b1;
    prev = own;
    run_txn(1'b0, 1'b1, own);
    chk("t5_resume_owner", 32'(own != prev), 32'd1);

    // Reset during an access aborts it.
    f_req = 1'b1; d_req = 1'b0; f_addr = 8'h44;
    step();
    chk("t6_gnt", 32'({f_gnt, d_gnt}), 32'd2);
    step();
    chk("t6_in_access", 32'(rram), 32'd0);
    rst = 1'b0; d_req = 1'b1;
    step();
    chk("t6_abort_strobes", 32'({wram, rram, ram_oe}), 32'b110);
    chk("t6_abort_ctl", 32'({busy, f_gnt, d_gnt, f_done, d_done}), 32'd0);
    chk("t6_abort_rdata", 32'({f_rdata, d_rdata}), 32'd0);
    last_owner = 1'b1;
    exp_f_rdata = '0;
    exp_d_rdata = '0;
    rst = 1'b1;
    run_txn(1'b0, 1'b1, own);
    chk("t6_fetch_first", 32'(own), 32'd0);

    // Randomized traffic over a small address window so reads hit earlier writes.
    for (int i = 0; i < 30; i++) begin
      r = 2'($urandom_range(1, 3));
      f_req   = r[0];
      d_req   = r[1];
      d_we    = 1'($urandom);
      f_addr  = 8'($urandom_range(0, 15));
      d_addr  = 8'($urandom_range(0, 15));
      d_wdata = 8'($urandom);
      run_txn(1'b0, 1'b1, own);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
